// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD-line responder: receives 48-bit host commands, hands them to a card
// model and serialises R1/R3/R6/R7 or R2 responses. Define SD_RSP_CRC_CHECK_EN to reject bad command CRCs.
module sd_cmd_responder #(
    parameter int NCR         = 2,
    parameter int RSP_TIMEOUT = 64
) (
    input  logic         msoc_clk,
    input  logic         rstn,
    input  logic         sd_sclk,
    input  logic         sd_cmd_in,
    output logic         sd_cmd_out,
    output logic         sd_cmd_oe,
    output logic         cmd_valid,
    output logic [5:0]   cmd_index,
    output logic [31:0]  cmd_arg,
    output logic         cmd_err,
    input  logic         rsp_valid,
    output logic         rsp_ready,
    input  logic [1:0]   rsp_len,
    input  logic [5:0]   rsp_index,
    input  logic [119:0] rsp_payload,
    output logic         rsp_timeout
);

    typedef enum logic [2:0] {IDLE, RX, WAIT_RSP, GAP, TX} state_t;

    localparam logic [6:0] NCR_C = 7'(NCR);
    localparam logic [6:0] TMO_C = 7'(RSP_TIMEOUT);

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:3], c[2] ^ fb, c[1:0], fb};
    endfunction

    // Synchronisers; rise/fall/cmd_bit are registered together so they stay aligned.
    logic sclk_s1, sclk_s2, sclk_prev;
    logic cmd_s1, cmd_s2, cmd_bit;
    logic rise, fall;

    always_ff @(posedge msoc_clk or negedge rstn) begin
        if (!rstn) begin
            sclk_s1   <= 1'b0;
            sclk_s2   <= 1'b0;
            sclk_prev <= 1'b0;
            cmd_s1    <= 1'b1;
            cmd_s2    <= 1'b1;
            cmd_bit   <= 1'b1;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            sclk_s1   <= sd_sclk;
            sclk_s2   <= sclk_s1;
            sclk_prev <= sclk_s2;
            cmd_s1    <= sd_cmd_in;
            cmd_s2    <= cmd_s1;
            cmd_bit   <= cmd_s2;
            rise      <= sclk_s2 & ~sclk_prev;
            fall      <= ~sclk_s2 & sclk_prev;
        end
    end

    state_t         state, state_n;
    logic [7:0]     bit_cnt, bit_cnt_n;
    logic [6:0]     wait_cnt, wait_cnt_n;
    logic [46:0]    rx_sr, rx_sr_n;
    logic [6:0]     rx_crc, rx_crc_n;
    logic [135:0]   tx_sr, tx_sr_n;
    logic           tx_long, tx_long_n;
    logic [6:0]     tx_crc, tx_crc_n;
    logic           cmd_out_n, cmd_oe_n;
    logic           cmd_valid_n, cmd_err_n, rsp_timeout_n, rsp_ready_n;
    logic [5:0]     cmd_index_n;
    logic [31:0]    cmd_arg_n;

    logic [47:0]    frame;
    logic [6:0]     wait_inc;
    logic [7:0]     clen;
    logic [7:0]     cstart;
    logic           crc_ok;
    logic           hs;

    always_ff @(posedge msoc_clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            bit_cnt     <= 8'd0;
            wait_cnt    <= 7'd0;
            rx_sr       <= 47'd0;
            rx_crc      <= 7'd0;
            tx_sr       <= 136'd0;
            tx_long     <= 1'b0;
            tx_crc      <= 7'd0;
            sd_cmd_out  <= 1'b1;
            sd_cmd_oe   <= 1'b0;
            cmd_valid   <= 1'b0;
            cmd_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_ready   <= 1'b0;
            cmd_index   <= 6'd0;
            cmd_arg     <= 32'd0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            wait_cnt    <= wait_cnt_n;
            rx_sr       <= rx_sr_n;
            rx_crc      <= rx_crc_n;
            tx_sr       <= tx_sr_n;
            tx_long     <= tx_long_n;
            tx_crc      <= tx_crc_n;
            sd_cmd_out  <= cmd_out_n;
            sd_cmd_oe   <= cmd_oe_n;
            cmd_valid   <= cmd_valid_n;
            cmd_err     <= cmd_err_n;
            rsp_timeout <= rsp_timeout_n;
            rsp_ready   <= rsp_ready_n;
            cmd_index   <= cmd_index_n;
            cmd_arg     <= cmd_arg_n;
        end
    end

    // Response handshake: a transfer happens in any cycle where rsp_valid and rsp_ready are
    // both 1; rsp_ready never depends on rsp_valid and drops the cycle after the transfer.
    always_comb begin
        state_n       = state;
        bit_cnt_n     = bit_cnt;
        wait_cnt_n    = wait_cnt;
        rx_sr_n       = rx_sr;
        rx_crc_n      = rx_crc;
        tx_sr_n       = tx_sr;
        tx_long_n     = tx_long;
        tx_crc_n      = tx_crc;
        cmd_out_n     = sd_cmd_out;
        cmd_oe_n      = sd_cmd_oe;
        cmd_valid_n   = 1'b0;
        cmd_err_n     = 1'b0;
        rsp_timeout_n = 1'b0;
        cmd_index_n   = cmd_index;
        cmd_arg_n     = cmd_arg;

        frame    = {rx_sr, cmd_bit};
        wait_inc = (wait_cnt == 7'h7F) ? wait_cnt : wait_cnt + 7'd1;
        clen     = tx_long ? 8'd128 : 8'd40;
        cstart   = tx_long ? 8'd8 : 8'd0;
        hs       = rsp_valid & rsp_ready;
`ifdef SD_RSP_CRC_CHECK_EN
        crc_ok   = (rx_crc == frame[7:1]);
`else
        crc_ok   = 1'b1;
`endif

        case (state)
            IDLE: begin
                if (rise && !cmd_bit) begin
                    state_n   = RX;
                    bit_cnt_n = 8'd1;
                    rx_sr_n   = 47'd0;
                    rx_crc_n  = 7'd0;
                end
            end
            RX: begin
                if (rise) begin
                    rx_sr_n   = frame[46:0];
                    bit_cnt_n = bit_cnt + 8'd1;
                    // CRC covers bits 1..40; the start bit leaves a zero CRC unchanged.
                    if (bit_cnt < 8'd40)
                        rx_crc_n = crc7_step(rx_crc, cmd_bit);
                    if (bit_cnt == 8'd47) begin
                        if (!frame[47] && frame[46] && frame[0] && crc_ok) begin
                            cmd_valid_n = 1'b1;
                            cmd_index_n = frame[45:40];
                            cmd_arg_n   = frame[39:8];
                            wait_cnt_n  = 7'd0;
                            state_n     = WAIT_RSP;
                        end else begin
                            cmd_err_n = 1'b1;
                            state_n   = IDLE;
                        end
                    end
                end
            end
            WAIT_RSP: begin
                if (rise)
                    wait_cnt_n = wait_inc;
                if (hs) begin
                    tx_long_n = (rsp_len == 2'd2);
                    tx_crc_n  = 7'd0;
                    bit_cnt_n = 8'd0;
                    if (rsp_len == 2'd1) begin
                        tx_sr_n = {2'b00, rsp_index, rsp_payload[31:0], 96'd0};
                        state_n = GAP;
                    end else if (rsp_len == 2'd2) begin
                        tx_sr_n = {2'b00, 6'h3F, rsp_payload, 8'd0};
                        state_n = GAP;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (rise && wait_inc >= TMO_C) begin
                    rsp_timeout_n = 1'b1;
                    state_n       = IDLE;
                end
            end
            GAP: begin
                if (rise)
                    wait_cnt_n = wait_inc;
                if (fall && wait_cnt >= NCR_C) begin
                    cmd_oe_n  = 1'b1;
                    cmd_out_n = tx_sr[135];
                    tx_sr_n   = {tx_sr[134:0], 1'b0};
                    bit_cnt_n = 8'd1;
                    state_n   = TX;
                end
            end
            TX: begin
                // bit_cnt counts bits already driven; content, then CRC, end bit, release.
                if (fall) begin
                    bit_cnt_n = bit_cnt + 8'd1;
                    if (bit_cnt < clen) begin
                        cmd_out_n = tx_sr[135];
                        tx_sr_n   = {tx_sr[134:0], 1'b0};
                        if (bit_cnt >= cstart)
                            tx_crc_n = crc7_step(tx_crc, tx_sr[135]);
                    end else if (bit_cnt < clen + 8'd7) begin
                        cmd_out_n = tx_crc[6];
                        tx_crc_n  = {tx_crc[5:0], 1'b0};
                    end else if (bit_cnt == clen + 8'd7) begin
                        cmd_out_n = 1'b1;
                    end else begin
                        cmd_oe_n  = 1'b0;
                        cmd_out_n = 1'b1;
                        state_n   = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        rsp_ready_n = (state == WAIT_RSP) && (state_n == WAIT_RSP);
    end

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Directed bench for sd_cmd_responder: a host model clocks commands in and samples
// responses on sclk rise; card-side events are counted by a msoc_clk monitor.
module tb_sd_cmd_responder;

    logic         msoc_clk;
    logic         rstn;
    logic         sd_sclk;
    logic         host_cmd;
    logic         sd_cmd_in;
    logic         sd_cmd_out;
    logic         sd_cmd_oe;
    logic         cmd_valid;
    logic [5:0]   cmd_index;
    logic [31:0]  cmd_arg;
    logic         cmd_err;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_len;
    logic [5:0]   rsp_index;
    logic [119:0] rsp_payload;
    logic         rsp_timeout;

    int errors = 0;
    int checks = 0;

    sd_cmd_responder #(.NCR(2), .RSP_TIMEOUT(64)) dut (
        .msoc_clk    (msoc_clk),
        .rstn        (rstn),
        .sd_sclk     (sd_sclk),
        .sd_cmd_in   (sd_cmd_in),
        .sd_cmd_out  (sd_cmd_out),
        .sd_cmd_oe   (sd_cmd_oe),
        .cmd_valid   (cmd_valid),
        .cmd_index   (cmd_index),
        .cmd_arg     (cmd_arg),
        .cmd_err     (cmd_err),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_len     (rsp_len),
        .rsp_index   (rsp_index),
        .rsp_payload (rsp_payload),
        .rsp_timeout (rsp_timeout)
    );

    // Shared CMD line: the card wins while it drives, otherwise the host value.
    assign sd_cmd_in = sd_cmd_oe ? sd_cmd_out : host_cmd;

    initial msoc_clk = 1'b0;
    always #5 msoc_clk = ~msoc_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Monitor of card-side pulses.
    int          rise_cnt = 0;
    int          n_valid = 0, n_err = 0, n_tmo = 0, n_oe = 0, tmo_rise = 0;
    logic [5:0]  last_idx = 6'd0;
    logic [31:0] last_arg = 32'd0;

    always @(posedge msoc_clk) begin
        if (cmd_valid) begin
            n_valid  <= n_valid + 1;
            last_idx <= cmd_index;
            last_arg <= cmd_arg;
        end
        if (cmd_err)     n_err <= n_err + 1;
        if (rsp_timeout) begin
            n_tmo    <= n_tmo + 1;
            tmo_rise <= rise_cnt;
        end
        if (sd_cmd_oe)   n_oe <= n_oe + 1;
    end

    task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic smp_cmd, smp_oe;

    // One sclk period: host value set during low phase, line sampled just before the rise.
    task automatic sclk_bit(input logic hv);
        host_cmd = hv;
        #80;
        smp_cmd = sd_cmd_in;
        smp_oe  = sd_cmd_oe;
        sd_sclk = 1'b1;
        rise_cnt++;
        #80;
        sd_sclk = 1'b0;
    endtask

    task automatic send_cmd(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) sclk_bit(f[i]);
        host_cmd = 1'b1;
    endtask

    task automatic get_rsp(input int nbits, output logic [135:0] r, output int idle,
                           output logic end_oe, output logic rel);
        logic started;
        r = '0; idle = 0; started = 1'b0; end_oe = 1'b0; rel = 1'b0;
        for (int k = 0; k < 200 && !started; k++) begin
            sclk_bit(1'b1);
            if (smp_oe && !smp_cmd) started = 1'b1;
            else idle++;
        end
        check("rsp_start_seen", started, 1);
        if (started) begin
            for (int j = 1; j < nbits; j++) begin
                sclk_bit(1'b1);
                r = {r[134:0], smp_cmd};
            end
            end_oe = smp_oe;
            sclk_bit(1'b1);
            rel = !smp_oe && smp_cmd;
        end
    endtask

    logic [135:0] r;
    int           idle, v0, e0, t0, o0, end_rise;
    logic         end_oe, rel;

    initial begin
        rstn = 1'b0; sd_sclk = 1'b0; host_cmd = 1'b1;
        rsp_valid = 1'b0; rsp_len = 2'd0; rsp_index = 6'd0; rsp_payload = '0;
        repeat (4) @(negedge msoc_clk);
        #2;
        check("reset_oe", sd_cmd_oe, 0);
        check("reset_out", sd_cmd_out, 1);
        check("reset_index", cmd_index, 0);
        check("reset_arg", cmd_arg, 0);
        check("reset_ready", rsp_ready, 0);
        rstn = 1'b1;
        #20;
        repeat (4) sclk_bit(1'b1);

        // CMD0, no response
        rsp_valid = 1'b1; rsp_len = 2'd0;
        v0 = n_valid; o0 = n_oe;
        send_cmd(48'h40_0000_0000_95);
        repeat (8) sclk_bit(1'b1);
        rsp_valid = 1'b0;
        check("cmd0_valid", n_valid - v0, 1);
        check("cmd0_index", last_idx, 6'd0);
        check("cmd0_arg", last_arg, 32'd0);
        check("cmd0_no_drive", n_oe - o0, 0);

        // CMD8 with R7
        rsp_valid = 1'b1; rsp_len = 2'd1; rsp_index = 6'd8; rsp_payload = 120'h1AA;
        send_cmd(48'h48_0000_01AA_87);
        get_rsp(48, r, idle, end_oe, rel);
        rsp_valid = 1'b0;
        check("cmd8_index", last_idx, 6'd8);
        check("cmd8_arg", last_arg, 32'h1AA);
        check("r7_frame", r[47:0], 48'h08_0000_01AA_13);
        check("r7_ncr_idle", idle, 2);
        check("r7_end_driven", end_oe, 1);
        check("r7_release", rel, 1);

        // CMD8 with a flipped argument bit
        rsp_valid = 1'b1; rsp_len = 2'd0;
        v0 = n_valid; e0 = n_err;
        send_cmd(48'h48_0000_01AB_87);
        repeat (8) sclk_bit(1'b1);
        rsp_valid = 1'b0;
`ifdef SD_RSP_CRC_CHECK_EN
        check("badcrc_err", n_err - e0, 1);
        check("badcrc_valid", n_valid - v0, 0);
`else
        check("badcrc_err", n_err - e0, 0);
        check("badcrc_valid", n_valid - v0, 1);
        check("badcrc_arg", last_arg, 32'h1AB);
`endif

        // CMD2 with R2, payload 1: CRC7 of 119 zeros then a one is 7'h09
        rsp_valid = 1'b1; rsp_len = 2'd2; rsp_payload = 120'h1;
        send_cmd(48'h42_0000_0000_4D);
        get_rsp(136, r, idle, end_oe, rel);
        rsp_valid = 1'b0;
        check("cmd2_index", last_idx, 6'd2);
        check("r2_frame", r, {2'b00, 6'h3F, 120'h1, 8'h13});
        check("r2_tail", r[7:0], 8'h13);
        check("r2_release", rel, 1);

        // CMD55 with no response offered
        v0 = n_valid; t0 = n_tmo;
        send_cmd(48'h77_0000_0000_65);
        end_rise = rise_cnt;
        repeat (70) sclk_bit(1'b1);
        check("cmd55_valid", n_valid - v0, 1);
        check("cmd55_index", last_idx, 6'h37);
        check("timeout_pulse", n_tmo - t0, 1);
        check("timeout_rises", tmo_rise - end_rise, 64);

        // Next CMD55 accepted normally
        rsp_valid = 1'b1; rsp_len = 2'd0;
        v0 = n_valid; e0 = n_err; t0 = n_tmo;
        send_cmd(48'h77_0000_0000_65);
        repeat (6) sclk_bit(1'b1);
        rsp_valid = 1'b0;
        check("cmd55b_valid", n_valid - v0, 1);
        check("cmd55b_err", n_err - e0, 0);
        check("cmd55b_no_timeout", n_tmo - t0, 0);

        // Reset in the middle of an R2 transmission
        rsp_valid = 1'b1; rsp_len = 2'd2; rsp_payload = 120'hABC;
        send_cmd(48'h42_0000_0000_4D);
        repeat (20) sclk_bit(1'b1);
        check("midtx_driving", sd_cmd_oe, 1);
        rstn = 1'b0;
        #1;
        check("reset_release_oe", sd_cmd_oe, 0);
        check("reset_release_out", sd_cmd_out, 1);
        #9;
        rsp_valid = 1'b0;
        #20;
        rstn = 1'b1;
        #20;
        repeat (2) sclk_bit(1'b1);

        v0 = n_valid;
        send_cmd(48'h40_0000_0000_95);
        repeat (6) sclk_bit(1'b1);
        check("post_reset_valid", n_valid - v0, 1);
        check("post_reset_index", last_idx, 6'd0);
        check("post_reset_arg", last_arg, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
